ifft8_serial: RTL and testbench
===============================

Name: ifft8_serial

Overview:
Sequential 8-point radix-2 DIT inverse FFT. It is the receive-side counterpart of the 8-point forward FFT: it takes 8 complex frequency bins and returns 8 complex time samples scaled by 1/8.
- Bins stream in over a valid/ready port.
- One shared butterfly, with a conjugate-twiddle unit, is time-multiplexed over 3 stages into an internal 8-entry complex buffer.
- Samples stream out in natural order.

Parameters:
W, 9, signed two's-complement width of every real/imag sample, in and out.
TW_Q, 181, magnitude of 0.707 twiddle in Q0.8 (181/256); the multiplier shift is fixed at 8.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  input bin valid.
in_ready  out  1  block accepts a bin this cycle.
in_re  in  W  bin real part, signed.
in_im  in  W  bin imag part, signed.
out_valid  out  1  output sample valid.
out_ready  in  1  consumer accepts the sample this cycle.
out_re  out  W  time sample real part, signed.
out_im  out  W  time sample imag part, signed.
out_idx  out  3  time index n of the presented sample.
busy  out  1  high in COMPUTE or UNLOAD.

Behaviour:
- Reset (async, any state): state=LOAD; counters=0; in_ready=1; out_valid=0; out_re=out_im=0; out_idx=0; busy=0. Buffer contents are don't-care.
- Handshakes: an input transfer occurs when in_valid&in_ready at the clock edge; an output transfer when out_valid&out_ready. Frames never overlap.
- LOAD:
  - in_ready=1.
  - The k-th accepted bin (k=0..7, natural order) is written to buffer address bitrev3(k).
  - On the 8th transfer (edge E), go to COMPUTE.
- COMPUTE:
  - in_ready=0, busy=1.
  - One butterfly per cycle: 3 stages x 4 butterflies = 12 cycles, at edges E+1..E+12.
  - Stage s (span h=1,2,4), butterfly pairs (a at i, b at i+h) are issued in ascending i.
  - Twiddle index j = i mod h; factor = W8^(-j*4/h).
  - The read and the write-back of a butterfly occur in the same cycle; no pairs overlap within a stage.
- UNLOAD:
  - Entered after edge E+12, so out_valid=1 from that cycle.
  - out_idx counts 0..7 and presents buffer[out_idx].
  - out_re, out_im and out_idx hold stable while out_valid&!out_ready.
  - After the transfer with out_idx=7: state=LOAD, out_valid=0, in_ready=1 on the next cycle.
- Twiddle products t = W^-k * b, with c=TW_Q and >>> meaning arithmetic shift (floor):
  - k=0: t = b (bypass, exact).
  - k=2 (+j): t = (-b_im, b_re), exact.
  - k=1 (0.707+j0.707): t_re = ((b_re-b_im)*c)>>>8; t_im = ((b_re+b_im)*c)>>>8.
  - k=3 (-0.707+j0.707): t_re = ((-(b_re+b_im))*c)>>>8; t_im = ((b_re-b_im)*c)>>>8.
- Intermediate widths: sums are formed at W+1 bits; products at W+10 bits before the shift.
- Butterfly outputs: a' = (a+t)>>>1 and b' = (a-t)>>>1, per component, computed at W+1 bits and then truncated to W.
- The per-stage /2 gives a total 1/8 scaling. There is no saturation; with |t| <= |b|*1.0 a W-bit result is guaranteed for W-bit inputs.
- Boundaries:
  - in_valid during COMPUTE or UNLOAD is ignored; in_ready=0.
  - out_ready during LOAD or COMPUTE has no effect.
  - rst in any state aborts the frame; the first bin after reset is k=0.

Test Plan:
- DC bin: X0=(200,0), X1..X7=(0,0) -> all 8 outputs (25,0), out_idx 0..7 in order.
- Flat spectrum: all Xk=(8,0) -> out (8,0) at n=0, (0,0) at n=1..7.
- Single tone: X1=(128,0), rest 0 -> n0=(16,0), n2=(0,16), n4=(-16,0), n6=(0,-16); n1,n3,n5,n7 each component within +/-1 of +/-11.3 with signs per e^{j2pi n/8}.
- Latency/throughput: 8 back-to-back bins with out_ready=1 -> out_valid rises exactly 12 cycles after the 8th input edge, 8 consecutive outputs follow, and in_ready returns 1 the cycle after out_idx=7 transfers.
- Backpressure: out_ready=0 for 5 cycles at out_idx=3 -> out_re/out_im/out_idx stable, no sample dropped or duplicated; in_ready stays 0.
- Async reset mid-COMPUTE (cycle E+6): outputs zero immediately, in_ready=1; the subsequent DC frame yields all (25,0).

Source files
------------

// File: rtl/ifft8_serial.sv
// 8-point radix-2 DIT inverse FFT, one shared butterfly over 3 stages, output scaled by 1/8.
// Latency: out_valid rises 12 cycles after the edge that accepts the 8th bin.
// Backpressure: in_ready low outside LOAD; while out_ready is low the presented sample holds.
module ifft8_serial #(
    parameter int W    = 9,
    parameter int TW_Q = 181
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic [2:0]          out_idx,
    output logic                busy
);

    localparam int WS = W + 1;
    localparam int WP = W + 10;
    localparam logic signed [WP-1:0] TW_C = WP'(TW_Q);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
    } cplx_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    cplx_t      mem [8];

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    // cnt[3:2] is the stage, cnt[1:0] the butterfly within it; a zero is
    // inserted at the stage's span bit so pairs come out in ascending i.
    logic [1:0] stage, pair, tw_k;
    logic [2:0] ia, ib;

    assign stage = cnt[3:2];
    assign pair  = cnt[1:0];

    always_comb begin
        ia   = '0;
        ib   = '0;
        tw_k = '0;
        case (stage)
            2'd0: begin
                ia   = {pair, 1'b0};
                ib   = {pair, 1'b1};
                tw_k = 2'd0;
            end
            2'd1: begin
                ia   = {pair[1], 1'b0, pair[0]};
                ib   = {pair[1], 1'b1, pair[0]};
                tw_k = {pair[0], 1'b0};
            end
            default: begin
                ia   = {1'b0, pair};
                ib   = {1'b1, pair};
                tw_k = pair;
            end
        endcase
    end

    cplx_t a, b, a_n, b_n;
    assign a = mem[ia];
    assign b = mem[ib];

    logic signed [WS-1:0] b_re_x, b_im_x, a_re_x, a_im_x, b_sum, b_dif;
    logic signed [WP-1:0] p_sum, p_dif, p_nsum;
    logic signed [WS-1:0] t_re, t_im, s_re_add, s_im_add, s_re_sub, s_im_sub;

    assign b_re_x = WS'($signed(b.re));
    assign b_im_x = WS'($signed(b.im));
    assign a_re_x = WS'($signed(a.re));
    assign a_im_x = WS'($signed(a.im));
    assign b_sum  = b_re_x + b_im_x;
    assign b_dif  = b_re_x - b_im_x;
    assign p_sum  = WP'(b_sum) * TW_C;
    assign p_dif  = WP'(b_dif) * TW_C;
    assign p_nsum = WP'(-b_sum) * TW_C;

    // Conjugate twiddles W8^-k: k=2 is +j, k=1/k=3 use the 0.707 multiplier.
    always_comb begin
        t_re = b_re_x;
        t_im = b_im_x;
        case (tw_k)
            2'd1: begin
                t_re = WS'(p_dif >>> 8);
                t_im = WS'(p_sum >>> 8);
            end
            2'd2: begin
                t_re = -b_im_x;
                t_im = b_re_x;
            end
            2'd3: begin
                t_re = WS'(p_nsum >>> 8);
                t_im = WS'(p_dif >>> 8);
            end
            default: ;
        endcase
    end

    assign s_re_add = a_re_x + t_re;
    assign s_im_add = a_im_x + t_im;
    assign s_re_sub = a_re_x - t_re;
    assign s_im_sub = a_im_x - t_im;

    assign a_n = {W'(s_re_add >>> 1), W'(s_im_add >>> 1)};
    assign b_n = {W'(s_re_sub >>> 1), W'(s_im_sub >>> 1)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LOAD;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Buffer contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid) begin
            mem[bitrev3(cnt[2:0])] <= {in_re, in_im};
        end else if (state == S_COMPUTE) begin
            mem[ia] <= a_n;
            mem[ib] <= b_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_re    = '0;
        out_im    = '0;
        out_idx   = '0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (cnt == 4'd7) begin
                        state_n = S_COMPUTE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (cnt == 4'd11) begin
                    state_n = S_UNLOAD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            S_UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_idx   = cnt[2:0];
                out_re    = mem[cnt[2:0]].re;
                out_im    = mem[cnt[2:0]].im;
                if (out_ready) begin
                    if (cnt == 4'd7) begin
                        state_n = S_LOAD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_n = S_LOAD;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ifft8_serial.sv
// Bench for ifft8_serial: scoreboard of expected time samples per frame,
// plus latency, backpressure and mid-frame reset checks.
module tb_ifft8_serial;

    localparam int W = 9;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic [2:0]          out_idx;
    logic                busy;

    ifft8_serial #(.W(W), .TW_Q(181)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int re;
        int im;
        int idx;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out    = 0;
    int   bin_re[8], bin_im[8], exp_re[8], exp_im[8];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge when valid&ready here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("sb_nonempty", (sb_q.size() > 0) ? 1 : 0, 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("out_idx", int'(out_idx), mon_e.idx);
                check("out_re", int'(out_re), mon_e.re);
                check("out_im", int'(out_im), mon_e.im);
                n_out++;
            end
        end
    end

    task automatic clear_frame();
        for (int k = 0; k < 8; k++) begin
            bin_re[k] = 0;
            bin_im[k] = 0;
            exp_re[k] = 0;
            exp_im[k] = 0;
        end
    endtask

    task automatic send_frame(input bit push);
        exp_t e;
        int   guard;
        if (push) begin
            for (int k = 0; k < 8; k++) begin
                e.re  = exp_re[k];
                e.im  = exp_im[k];
                e.idx = k;
                sb_q.push_back(e);
            end
        end
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_re    = W'(bin_re[k]);
            in_im    = W'(bin_im[k]);
            guard    = 0;
            while (!in_ready && guard < 100) begin
                @(posedge clk);
                #1;
                guard++;
            end
            check("load_ready_wait", guard, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Called at #1 after the edge that accepted the 8th bin.
    task automatic measure_latency();
        int cyc;
        check("compute_busy", int'(busy), 1);
        check("compute_in_ready", int'(in_ready), 0);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, 12);
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (!(out_valid && out_idx == 3'd7) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("unload_last_idx", int'(out_idx), 7);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_return", int'(in_ready), 1);
        check("out_valid_clear", int'(out_valid), 0);
        check("busy_clear", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int   guard;
        int   hold_re, hold_im, hold_idx;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_re", int'(out_re), 0);
        check("rst_out_im", int'(out_im), 0);
        check("rst_out_idx", int'(out_idx), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // DC bin
        clear_frame();
        bin_re[0] = 200;
        for (int k = 0; k < 8; k++) exp_re[k] = 25;
        send_frame(1'b1);
        measure_latency();
        wait_done();

        // Flat spectrum, with in_valid held high (junk) while busy
        clear_frame();
        for (int k = 0; k < 8; k++) bin_re[k] = 8;
        exp_re[0] = 8;
        send_frame(1'b1);
        in_valid = 1'b1;
        in_re    = 9'sd99;
        in_im    = -9'sd5;
        measure_latency();
        wait_done();

        // Real tone at bin 1
        clear_frame();
        bin_re[1] = 128;
        exp_re = '{16, 11, 0, -12, -16, -11, 0, 11};
        exp_im = '{0, 11, 16, 11, 0, -11, -16, -11};
        send_frame(1'b1);
        measure_latency();
        wait_done();

        // Imaginary tone at bin 1
        clear_frame();
        bin_im[1] = 128;
        exp_re = '{0, -12, -16, -12, 0, 11, 16, 11};
        exp_im = '{16, 11, 0, -12, -16, -11, 0, 11};
        send_frame(1'b1);
        measure_latency();
        wait_done();

        // Tone at bin 2, with output backpressure at n=3
        clear_frame();
        bin_re[2] = 64;
        exp_re = '{8, 0, -8, 0, 8, 0, -8, 0};
        exp_im = '{0, 8, 0, -8, 0, 8, 0, -8};
        send_frame(1'b1);
        measure_latency();
        guard = 0;
        while (!(out_valid && out_idx == 3'd3) && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        out_ready = 1'b0;
        hold_re   = int'(out_re);
        hold_im   = int'(out_im);
        hold_idx  = int'(out_idx);
        check("bp_start_idx", hold_idx, 3);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_hold_re", int'(out_re), hold_re);
            check("bp_hold_im", int'(out_im), hold_im);
            check("bp_hold_idx", int'(out_idx), hold_idx);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        wait_done();

        // Abort a frame with async reset in the middle of COMPUTE
        clear_frame();
        bin_re[3] = 100;
        bin_im[5] = -70;
        send_frame(1'b0);
        repeat (6) @(posedge clk);
        #2;
        check("pre_abort_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out_re", int'(out_re), 0);
        check("abort_out_im", int'(out_im), 0);
        check("abort_out_idx", int'(out_idx), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // DC frame after the abort must start cleanly at k=0
        clear_frame();
        bin_re[0] = 200;
        for (int k = 0; k < 8; k++) exp_re[k] = 25;
        send_frame(1'b1);
        measure_latency();
        wait_done();

        repeat (3) @(posedge clk);
        #1;
        check("sb_leftover", sb_q.size(), 0);
        check("outputs_seen", n_out, 48);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
